// File: rtl/fifo_n_pipe_if.sv
// Handshake bundle for fifo_n_pipe: enqueue/dequeue guarded methods plus status.
// master = producer/consumer side, slave = the FIFO itself.
interface fifo_n_pipe_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_enq__ENA;
    logic [WIDTH-1:0] in_enq_v;
    logic             in_enq__RDY;
    logic             out_deq__ENA;
    logic             out_deq__RDY;
    logic [WIDTH-1:0] out_first;
    logic             out_first__RDY;
    logic [CW-1:0]    count;
    logic             almost_full;

    modport master (
        output in_enq__ENA, in_enq_v, out_deq__ENA,
        input  in_enq__RDY, out_deq__RDY, out_first, out_first__RDY, count, almost_full
    );

    modport slave (
        input  in_enq__ENA, in_enq_v, out_deq__ENA,
        output in_enq__RDY, out_deq__RDY, out_first, out_first__RDY, count, almost_full
    );
endinterface

// File: rtl/fifo_n_pipe.sv
// N-entry FIFO with guarded enq/deq methods, occupancy count, almost-full flag
// and optional pipelined mode (enq accepted while full when a deq fires too).
module fifo_n_pipe #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 4,
    parameter int AF_LEVEL  = 3,
    parameter int PIPELINED = 0
) (
    input logic           CLK,
    input logic           RST,
    fifo_n_pipe_if.slave  bus
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);
    localparam bit            PIPE    = (PIPELINED != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             not_empty, not_full, enq_fire, deq_fire;

    always_comb begin
        not_empty          = (count_q != '0);
        not_full           = (count_q != DEPTH_C);
        // Pipelined mode: a full FIFO can accept because the head slot frees this cycle.
        bus.in_enq__RDY    = not_full || (PIPE && bus.out_deq__ENA && not_empty);
        bus.out_deq__RDY   = not_empty;
        bus.out_first__RDY = not_empty;
        bus.out_first      = mem_q[rd_ptr_q];
        bus.count          = count_q;
        bus.almost_full    = (count_q >= AF_C);

        enq_fire = bus.in_enq__ENA && bus.in_enq__RDY;
        deq_fire = bus.out_deq__ENA && not_empty;

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (enq_fire) begin
            mem_d[wr_ptr_q] = bus.in_enq_v;
            wr_ptr_d        = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PW'(1);
        end
        if (deq_fire) begin
            rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PW'(1);
        end
        if (enq_fire && !deq_fire) begin
            count_d = count_q + CW'(1);
        end else if (deq_fire && !enq_fire) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; contents are only visible through count.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_fifo_n_pipe.sv
// Drives four FIFO configurations with shared stimulus and checks every cycle
// against a queue-based model, plus literal expectations for key scenarios.
module tb_fifo_n_pipe;
    localparam int NI = 4;
    localparam int DEP [NI] = '{4, 4, 3, 1};
    localparam int PIP [NI] = '{0, 1, 0, 0};
    localparam int AFL [NI] = '{3, 3, 2, 1};

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       en  = 1'b0;
    logic       de  = 1'b0;
    logic [7:0] v   = 8'h00;

    logic       o_rdy_e [NI];
    logic       o_rdy_d [NI];
    logic       o_frdy  [NI];
    logic [7:0] o_first [NI];
    logic [7:0] o_cnt   [NI];
    logic       o_af    [NI];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mq [NI][$];

    always #5 CLK = ~CLK;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        fifo_n_pipe_if #(.WIDTH(8), .DEPTH(DEP[k])) bus ();
        assign bus.in_enq__ENA  = en;
        assign bus.in_enq_v     = v;
        assign bus.out_deq__ENA = de;
        fifo_n_pipe #(
            .WIDTH(8), .DEPTH(DEP[k]), .AF_LEVEL(AFL[k]), .PIPELINED(PIP[k])
        ) dut (
            .CLK(CLK),
            .RST(RST),
            .bus(bus.slave)
        );
        assign o_rdy_e[k] = bus.in_enq__RDY;
        assign o_rdy_d[k] = bus.out_deq__RDY;
        assign o_frdy[k]  = bus.out_first__RDY;
        assign o_first[k] = bus.out_first;
        assign o_cnt[k]   = 8'(bus.count);
        assign o_af[k]    = bus.almost_full;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_rdy_e(input int k);
        int sz;
        sz = mq[k].size();
        return int'((sz != DEP[k]) || (PIP[k] != 0 && de && sz != 0));
    endfunction

    // Reference model: plain queues, one per configuration.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NI; k++) mq[k].delete();
        end else begin
            for (int k = 0; k < NI; k++) begin
                bit fe, fd;
                fe = en && (exp_rdy_e(k) != 0);
                fd = de && (mq[k].size() != 0);
                if (fd) void'(mq[k].pop_front());
                if (fe) mq[k].push_back(v);
            end
        end
    end

    always @(negedge CLK) begin
        int sz;
        for (int k = 0; k < NI; k++) begin
            sz = mq[k].size();
            chk($sformatf("enq_rdy[%0d]", k), int'(o_rdy_e[k]), exp_rdy_e(k));
            chk($sformatf("deq_rdy[%0d]", k), int'(o_rdy_d[k]), int'(sz != 0));
            chk($sformatf("first_rdy[%0d]", k), int'(o_frdy[k]), int'(sz != 0));
            chk($sformatf("count[%0d]", k), int'(o_cnt[k]), sz);
            chk($sformatf("almost_full[%0d]", k), int'(o_af[k]), int'(sz >= AFL[k]));
            if (sz != 0) chk($sformatf("first[%0d]", k), int'(o_first[k]), int'(mq[k][0]));
        end
    end

    // Apply one cycle of inputs, then return idle inputs at posedge+2.
    task automatic cyc(input bit e, input bit d, input logic [7:0] val);
        en = e; de = d; v = val;
        @(posedge CLK); #1;
        en = 1'b0; de = 1'b0;
        #1;
    endtask

    initial begin
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h22, 8'h33, 8'h44, 8'h55};

        #2;
        chk("reset_count", int'(o_cnt[0]), 0);
        chk("reset_enq_rdy", int'(o_rdy_e[0]), 1);
        chk("reset_deq_rdy", int'(o_rdy_d[0]), 0);
        chk("reset_af", int'(o_af[0]), 0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        #1;

        // Fill the depth-4 instances.
        cyc(1, 0, 8'h11);
        chk("fill1_count", int'(o_cnt[0]), 1);
        chk("fill1_first", int'(o_first[0]), 'h11);
        cyc(1, 0, 8'h22);
        chk("fill2_af", int'(o_af[0]), 0);
        cyc(1, 0, 8'h33);
        chk("fill3_af", int'(o_af[0]), 1);
        cyc(1, 0, 8'h44);
        chk("fill4_count", int'(o_cnt[0]), 4);
        chk("fill4_enq_rdy", int'(o_rdy_e[0]), 0);
        chk("d3_full_count", int'(o_cnt[2]), 3);

        // Enq+deq while full: plain mode drops the enq, pipelined mode takes it.
        cyc(1, 1, 8'h55);
        chk("full_p0_count", int'(o_cnt[0]), 3);
        chk("full_p0_head", int'(o_first[0]), 'h22);
        chk("full_p1_count", int'(o_cnt[1]), 4);
        chk("full_p1_head", int'(o_first[1]), 'h22);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("p1_drain%0d", i), int'(o_first[1]), int'(exp_seq[i]));
            cyc(0, 1, 8'h00);
        end
        chk("drained_p1_count", int'(o_cnt[1]), 0);

        // Deq on empty is ignored; enq alone lands.
        cyc(1, 1, 8'hAA);
        chk("empty_deq_count", int'(o_cnt[0]), 1);
        chk("empty_deq_first", int'(o_first[0]), 'hAA);
        cyc(0, 1, 8'h00);

        // Wrap the depth-3 instance several times.
        for (int i = 1; i <= 7; i++) begin
            cyc(1, 0, 8'(i));
            chk($sformatf("wrap_first%0d", i), int'(o_first[2]), i);
            cyc(0, 1, 8'h00);
        end
        for (int i = 1; i <= 7; i++) cyc(1, i[0], 8'(8'h60 + i));
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00);

        // Async reset between edges clears state before the next edge.
        cyc(1, 0, 8'h81);
        cyc(1, 0, 8'h82);
        chk("pre_rst_count", int'(o_cnt[0]), 2);
        #1 RST = 1'b1;
        #1;
        chk("mid_rst_count", int'(o_cnt[0]), 0);
        chk("mid_rst_first_rdy", int'(o_frdy[0]), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        cyc(1, 0, 8'h5A);
        chk("post_rst_first", int'(o_first[0]), 'h5A);
        chk("post_rst_count", int'(o_cnt[0]), 1);
        cyc(0, 1, 8'h00);

        // Randomised phase with shifting bias to hit both full and empty.
        for (int i = 0; i < 3000; i++) begin
            int pe, pd;
            pe = ((i / 250) % 2 == 0) ? 70 : 35;
            pd = ((i / 250) % 2 == 0) ? 35 : 70;
            en = ($urandom_range(0, 99) < pe);
            de = ($urandom_range(0, 99) < pd);
            v  = 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #1 RST = 1'b1;
                #1 RST = 1'b0;
            end
            @(posedge CLK); #2;
        end
        en = 1'b0; de = 1'b0;
        @(posedge CLK); #6;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
